// File: rtl/jtframe_nvram_lanes.sv
// Dual-port byte-lane NVRAM with a byte-serial dump sequencer and dirty tracking.
// Optional post-reset clear sweep: define JTFRAME_NVRAM_CLR_EN.
module jtframe_nvram_lanes #(
  parameter int unsigned AW         = 10,
  parameter int unsigned LANES      = 2,
  parameter string       SIMHEXFILE = "",
  parameter logic [7:0]  CLR_VAL    = 8'hFF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [AW-1:0]                addr0,
  input  logic [8*LANES-1:0]           data0,
  input  logic [LANES-1:0]             we0,
  output logic [8*LANES-1:0]           q0,
  input  logic [AW-1:0]                addr1a,
  output logic [8*LANES-1:0]           q1a,
  input  logic [AW+$clog2(LANES)-1:0]  addr1b,
  input  logic [7:0]                   data1,
  input  logic                         we1b,
  input  logic                         sel_b,
  output logic [7:0]                   q1b,
  input  logic                         dump_req,
  input  logic                         dump_ready,
  output logic                         dump_valid,
  output logic [AW+$clog2(LANES)-1:0]  dump_addr,
  output logic [7:0]                   dump_dout,
  output logic                         busy,
  output logic                         dirty
);

  localparam int unsigned DW    = 8 * LANES;
  localparam int unsigned LB    = $clog2(LANES);
  localparam int unsigned LBW   = (LB == 0) ? 1 : LB;
  localparam int unsigned PW    = AW + LB;
  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WT, S_VL, S_DONE
`ifdef JTFRAME_NVRAM_CLR_EN
    , S_CLR
`endif
  } state_t;

  logic [DW-1:0]  mem [DEPTH];
  state_t         state, state_d;
  logic [PW-1:0]  ptr, ptr_d;
  logic [DW-1:0]  seq_word;
  logic           idle_c, wr1_c, clr_we_c, wr_any_c;
  logic [AW-1:0]  p1_word_c;
  logic [LBW-1:0] lane1_c, seq_lane_c;
  logic [DW-1:0]  p1_rd_c;

  assign idle_c     = state == S_IDLE;
  assign wr1_c      = idle_c & sel_b & we1b;
  assign p1_word_c  = sel_b ? AW'(addr1b >> LB) : addr1a;
  assign lane1_c    = LBW'(addr1b & PW'(LANES - 1));
  assign seq_lane_c = LBW'(ptr & PW'(LANES - 1));
  assign p1_rd_c    = mem[p1_word_c];
`ifdef JTFRAME_NVRAM_CLR_EN
  // First cycle after reset only raises busy; the sweep writes on the following 2**AW cycles
  assign clr_we_c   = (state == S_CLR) & busy;
`else
  assign clr_we_c   = 1'b0;
`endif
  assign wr_any_c   = (|we0) | wr1_c | clr_we_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef JTFRAME_NVRAM_CLR_EN
      state <= S_CLR;
`else
      state <= S_IDLE;
`endif
      ptr   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
    end
  end

  // Sequencer next state
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    case (state)
      S_IDLE: if (dump_req) begin
        state_d = S_RD;
        ptr_d   = '0;
      end
      S_RD:   state_d = S_WT;
      S_WT:   state_d = S_VL;
      S_VL:   if (dump_ready) begin
        if (ptr == '1) state_d = S_DONE;
        else begin
          ptr_d   = ptr + PW'(1);
          state_d = S_RD;
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef JTFRAME_NVRAM_CLR_EN
      S_CLR:  if (busy) begin
        if (ptr == PW'(DEPTH - 1)) state_d = S_IDLE;
        else ptr_d = ptr + PW'(1);
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Storage: sweep, then port 1 byte, then port 0 lanes so port 0 wins any overlap
  always_ff @(posedge clk) begin
    if (clr_we_c) mem[AW'(ptr)] <= {LANES{CLR_VAL}};
    for (int k = 0; k < int'(LANES); k++) begin
      if (wr1_c && lane1_c == LBW'(k)) mem[p1_word_c][8*k +: 8] <= data1;
    end
    for (int k = 0; k < int'(LANES); k++) begin
      if (we0[k]) mem[addr0][8*k +: 8] <= data0[8*k +: 8];
    end
  end

  // Read ports, dump outputs and dirty flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0         <= '0;
      q1a        <= '0;
      q1b        <= '0;
      seq_word   <= '0;
      dump_addr  <= '0;
      dump_dout  <= '0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      dirty      <= 1'b0;
    end else begin
      q0 <= mem[addr0];
      if (idle_c) begin
        q1a <= p1_rd_c;
        q1b <= 8'(p1_rd_c >> {lane1_c, 3'b000});
      end
      if (state == S_RD) seq_word <= mem[AW'(ptr >> LB)];
      if (state == S_WT) begin
        dump_dout <= 8'(seq_word >> {seq_lane_c, 3'b000});
        dump_addr <= ptr;
      end
      dump_valid <= state_d == S_VL;
      busy       <= state_d != S_IDLE;
      if (state == S_DONE) dirty <= wr_any_c;
      else if (wr_any_c)   dirty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtframe_nvram_lanes.sv
// Directed bench for jtframe_nvram_lanes (AW=4, LANES=2); follows JTFRAME_NVRAM_CLR_EN if defined.
module tb_jtframe_nvram_lanes;

  localparam int AW = 4;
  localparam int LANES = 2;
  localparam int WORDS = 16;
  localparam int BYTES = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  addr0, addr1a;
  logic [15:0] data0, q0, q1a;
  logic [1:0]  we0;
  logic [4:0]  addr1b, dump_addr;
  logic [7:0]  data1, q1b, dump_dout;
  logic        we1b, sel_b, dump_req, dump_ready, dump_valid, busy, dirty;

  jtframe_nvram_lanes #(.AW(AW), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n),
    .addr0(addr0), .data0(data0), .we0(we0), .q0(q0),
    .addr1a(addr1a), .q1a(q1a),
    .addr1b(addr1b), .data1(data1), .we1b(we1b), .sel_b(sel_b), .q1b(q1b),
    .dump_req(dump_req), .dump_ready(dump_ready), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_dout(dump_dout), .busy(busy), .dirty(dirty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we0;
    logic [3:0]  addr0;
    logic [15:0] data0;
    logic        sel_b;
    logic        we1b;
    logic [3:0]  addr1a;
    logic [4:0]  addr1b;
    logic [7:0]  data1;
    logic [2:0]  mask;     // bit0 q0, bit1 q1a, bit2 q1b
    logic [15:0] e_q0;
    logic [15:0] e_q1a;
    logic [7:0]  e_q1b;
    logic        e_dirty;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] model [WORDS];
  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] w0, input logic [3:0] a0, input logic [15:0] d0,
                              input logic sb, input logic w1, input logic [3:0] a1a,
                              input logic [4:0] a1b, input logic [7:0] d1, input logic [2:0] m,
                              input logic [15:0] eq0, input logic [15:0] eq1a,
                              input logic [7:0] eq1b, input logic ed);
    vec_t v;
    v.we0 = w0; v.addr0 = a0; v.data0 = d0; v.sel_b = sb; v.we1b = w1;
    v.addr1a = a1a; v.addr1b = a1b; v.data1 = d1; v.mask = m;
    v.e_q0 = eq0; v.e_q1a = eq1a; v.e_q1b = eq1b; v.e_dirty = ed;
    return v;
  endfunction

  task automatic idle_inputs();
    addr0 = '0; data0 = '0; we0 = '0; addr1a = '0; addr1b = '0; data1 = '0;
    we1b = 1'b0; sel_b = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
  endtask

  task automatic do_reset();
    int cnt;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_q0", 32'(q0), 32'h0);
    chk("rst_q1a", 32'(q1a), 32'h0);
    chk("rst_q1b", 32'(q1b), 32'h0);
    chk("rst_dump_valid", 32'(dump_valid), 32'h0);
    chk("rst_dump_addr", 32'(dump_addr), 32'h0);
    chk("rst_dump_dout", 32'(dump_dout), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_dirty", 32'(dirty), 32'h0);
    rst_n = 1'b1;
`ifdef JTFRAME_NVRAM_CLR_EN
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("clr_busy_cycles", 32'(cnt), 32'd16);
    chk("clr_dirty", 32'(dirty), 32'h1);
    for (int w = 0; w < WORDS; w++) model[w] = 16'hFFFF;
    for (int w = 0; w < WORDS; w += 5) begin
      addr1a = 4'(w);
      @(posedge clk); #1;
      chk("clr_q1a", 32'(q1a), 32'hFFFF);
      @(negedge clk);
    end
    addr1a = '0;
`else
    cnt = 0;
    @(negedge clk);
    chk("noclr_busy", 32'(busy), 32'h0);
`endif
  endtask

  task automatic run_dump(input bit rnd, input bit wr_done, input string tag);
    int n, cyc;
    bit pend;
    logic [7:0] pd, eb;
    logic [4:0] pa;
    logic [15:0] hold_q1a;
    n = 0; cyc = 0; pend = 1'b0; pd = '0; pa = '0;
    @(negedge clk);
    dump_req = 1'b1;
    dump_ready = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    chk({tag, "_busy_start"}, 32'(busy), 32'h1);
    hold_q1a = q1a;
    while (busy && cyc < 2000) begin
      cyc++;
      dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      // Port-1 traffic during the dump must be dropped
      sel_b = (n < BYTES); we1b = (n < BYTES); addr1b = 5'(cyc); data1 = 8'hEE; addr1a = 4'(cyc);
      if (wr_done && n == BYTES && !dump_valid) begin
        we0 = 2'b01; addr0 = 4'd6; data0 = 16'h0066; model[6][7:0] = 8'h66;
      end else we0 = 2'b00;
      if (pend) begin
        chk({tag, "_hold_valid"}, 32'(dump_valid), 32'h1);
        chk({tag, "_hold_dout"}, 32'(dump_dout), 32'(pd));
        chk({tag, "_hold_addr"}, 32'(dump_addr), 32'(pa));
        pend = 1'b0;
      end
      if (dump_valid) begin
        if (dump_ready) begin
          eb = 8'(model[n / 2] >> (8 * (n % 2)));
          chk({tag, "_byte"}, 32'(dump_dout), 32'(eb));
          chk({tag, "_addr"}, 32'(dump_addr), 32'(n));
          n++;
        end else begin
          pend = 1'b1; pd = dump_dout; pa = dump_addr;
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    if (!rnd) chk({tag, "_busy_cycles"}, 32'(cyc), 32'd97);
    chk({tag, "_bytes"}, 32'(n), 32'd32);
    chk({tag, "_busy_end"}, 32'(busy), 32'h0);
    chk({tag, "_q1a_held"}, 32'(q1a), 32'(hold_q1a));
    chk({tag, "_dirty_end"}, 32'(dirty), 32'(wr_done));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    vecs[0]  = mk(2'b00, 4'd0,  16'h0000, 1'b0, 1'b0, 4'd1, 5'd0,  8'h00, 3'b011, 16'h1000, 16'h1101, 8'h00, 1'b0);
    vecs[1]  = mk(2'b00, 4'd2,  16'h0000, 1'b1, 1'b1, 4'd0, 5'd5,  8'h5A, 3'b111, 16'h1202, 16'h1202, 8'h12, 1'b1);
    vecs[2]  = mk(2'b00, 4'd2,  16'h0000, 1'b0, 1'b0, 4'd2, 5'd0,  8'h00, 3'b011, 16'h5A02, 16'h5A02, 8'h00, 1'b1);
    vecs[3]  = mk(2'b10, 4'd3,  16'hABCD, 1'b1, 1'b0, 4'd0, 5'd7,  8'h00, 3'b001, 16'h1303, 16'h0000, 8'h00, 1'b1);
    vecs[4]  = mk(2'b00, 4'd3,  16'h0000, 1'b1, 1'b0, 4'd0, 5'd7,  8'h00, 3'b111, 16'hAB03, 16'hAB03, 8'hAB, 1'b1);
    vecs[5]  = mk(2'b00, 4'd3,  16'h0000, 1'b1, 1'b0, 4'd0, 5'd6,  8'h00, 3'b111, 16'hAB03, 16'hAB03, 8'h03, 1'b1);
    vecs[6]  = mk(2'b00, 4'd4,  16'h0000, 1'b0, 1'b1, 4'd4, 5'd8,  8'h77, 3'b011, 16'h1404, 16'h1404, 8'h00, 1'b1);
    vecs[7]  = mk(2'b00, 4'd4,  16'h0000, 1'b0, 1'b0, 4'd4, 5'd0,  8'h00, 3'b011, 16'h1404, 16'h1404, 8'h00, 1'b1);
    vecs[8]  = mk(2'b01, 4'd1,  16'h0011, 1'b1, 1'b1, 4'd0, 5'd2,  8'h22, 3'b101, 16'h1101, 16'h0000, 8'h01, 1'b1);
    vecs[9]  = mk(2'b00, 4'd1,  16'h0000, 1'b1, 1'b0, 4'd0, 5'd2,  8'h00, 3'b111, 16'h1111, 16'h1111, 8'h11, 1'b1);
    vecs[10] = mk(2'b11, 4'd15, 16'hBEEF, 1'b1, 1'b0, 4'd0, 5'd31, 8'h00, 3'b001, 16'h1F0F, 16'h0000, 8'h00, 1'b1);
    vecs[11] = mk(2'b00, 4'd15, 16'h0000, 1'b1, 1'b0, 4'd0, 5'd31, 8'h00, 3'b111, 16'hBEEF, 16'hBEEF, 8'hBE, 1'b1);
    vecs[12] = mk(2'b00, 4'd0,  16'h0000, 1'b1, 1'b0, 4'd0, 5'd30, 8'h00, 3'b101, 16'h1000, 16'h0000, 8'hEF, 1'b1);
    vecs[13] = mk(2'b00, 4'd0,  16'h0000, 1'b1, 1'b1, 4'd0, 5'd0,  8'hC3, 3'b111, 16'h1000, 16'h1000, 8'h00, 1'b1);
    vecs[14] = mk(2'b00, 4'd0,  16'h0000, 1'b0, 1'b0, 4'd0, 5'd0,  8'h00, 3'b011, 16'h10C3, 16'h10C3, 8'h00, 1'b1);

    do_reset();

    // Known image: word w = {0x10+w, w}
    for (int w = 0; w < WORDS; w++) begin
      @(negedge clk);
      we0 = 2'b11; addr0 = 4'(w); data0 = {8'(8'h10 + w), 8'(w)};
      model[w] = data0;
    end
    @(negedge clk);
    we0 = 2'b00;
    @(negedge clk);
    chk("fill_dirty", 32'(dirty), 32'h1);

    run_dump(1'b0, 1'b0, "dump_full");

    foreach (vecs[i]) begin
      @(negedge clk);
      we0 = vecs[i].we0; addr0 = vecs[i].addr0; data0 = vecs[i].data0;
      sel_b = vecs[i].sel_b; we1b = vecs[i].we1b; addr1a = vecs[i].addr1a;
      addr1b = vecs[i].addr1b; data1 = vecs[i].data1;
      @(posedge clk); #1;
      if (vecs[i].mask[0]) chk($sformatf("vec%0d_q0", i), 32'(q0), 32'(vecs[i].e_q0));
      if (vecs[i].mask[1]) chk($sformatf("vec%0d_q1a", i), 32'(q1a), 32'(vecs[i].e_q1a));
      if (vecs[i].mask[2]) chk($sformatf("vec%0d_q1b", i), 32'(q1b), 32'(vecs[i].e_q1b));
      chk($sformatf("vec%0d_dirty", i), 32'(dirty), 32'(vecs[i].e_dirty));
      if (vecs[i].sel_b && vecs[i].we1b) begin
        if (vecs[i].addr1b[0]) model[vecs[i].addr1b[4:1]][15:8] = vecs[i].data1;
        else                   model[vecs[i].addr1b[4:1]][7:0]  = vecs[i].data1;
      end
      if (vecs[i].we0[0]) model[vecs[i].addr0][7:0]  = vecs[i].data0[7:0];
      if (vecs[i].we0[1]) model[vecs[i].addr0][15:8] = vecs[i].data0[15:8];
    end
    @(negedge clk);
    idle_inputs();

    run_dump(1'b1, 1'b1, "dump_rand");

    // Abort a dump with reset while a byte is on offer
    @(negedge clk);
    we0 = 2'b10; addr0 = 4'd5; data0 = 16'h6600; model[5][15:8] = 8'h66;
    @(negedge clk);
    we0 = 2'b00; dump_req = 1'b1; dump_ready = 1'b0;
    @(negedge clk);
    dump_req = 1'b0;
    cyc = 0;
    while (!dump_valid && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    chk("abort_valid", 32'(dump_valid), 32'h1);
    chk("abort_first_byte", 32'(dump_dout), 32'(model[0][7:0]));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy_async", 32'(busy), 32'h0);
    chk("abort_valid_async", 32'(dump_valid), 32'h0);
    chk("abort_dirty", 32'(dirty), 32'h0);
    do_reset();
    @(negedge clk);
    addr0 = 4'd5;
    @(posedge clk); #1;
    chk("post_reset_word5", 32'(q0), 32'(model[5]));
    @(negedge clk);
    addr0 = 4'd3;
    @(posedge clk); #1;
    chk("post_reset_word3", 32'(q0), 32'(model[3]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
